// File: rtl/autoconfig_pkg.sv
// Shared AutoConfig types: bus-cycle states, ROM/register offsets,
// and type/flag nibbles used by the responder and its ROM.
package autoconfig_pkg;

  typedef enum logic [1:0] {
    Z3_IDLE  = 2'd0,
    Z3_START = 2'd1,
    Z3_DATA  = 2'd2,
    Z3_END   = 2'd3
  } z3_state_t;

  localparam logic [6:0] ER_TYPE   = 7'h00;
  localparam logic [6:0] ER_PROD   = 7'h02;
  localparam logic [6:0] ER_FLAGS  = 7'h04;
  localparam logic [6:0] ER_MFG    = 7'h08;
  localparam logic [6:0] ER_SERIAL = 7'h0C;
  localparam logic [6:0] ER_DIAG   = 7'h14;
  localparam logic [6:0] ER_RSVD   = 7'h20;

  localparam logic [5:0] ER_BASE_HI = 6'h11;
  localparam logic [5:0] ER_BASE_LO = 6'h12;
  localparam logic [5:0] ER_SHUTUP  = 6'h13;

  localparam logic [3:0] TYPE_Z3  = 4'hA;
  localparam logic [3:0] TYPE_Z2  = 4'hE;
  localparam logic [3:0] FLAGS_Z3 = 4'hB;
  localparam logic [3:0] FLAGS_Z2 = 4'hC;
  localparam logic [3:0] FLAGS_LO = 4'h1;

  localparam logic [15:0] DIAG_VEC = 16'h0010;

endpackage

// File: rtl/autoconfig_rom.sv
// Combinational AutoConfig ROM nibble lookup for one logical board.
// AUTOCFG_DIAGROM_EN adds the diag ROM bit and vector on board 0.
module autoconfig_rom
  import autoconfig_pkg::*;
#(
  parameter int          NUM_BOARDS = 2,
  parameter int          ZORRO3     = 1,
  parameter logic [2:0]  SIZE_CODE  = 3'b100,
  parameter logic [15:0] MFG_ID     = 16'h07DB,
  parameter logic [7:0]  PROD_ID    = 8'h72,
  parameter logic [31:0] SERIAL     = 32'd421
) (
  input  logic [6:0] idx,
  input  logic [1:0] board,
  output logic [3:0] nib
);

  logic [7:0] prod;
  logic       chain;
  logic [3:0] type_nib;
  logic [3:0] flag_nib;
  logic [1:0] mo;
  logic [2:0] so;

  always_comb begin
    prod     = PROD_ID + {6'd0, board};
    chain    = int'(board) < NUM_BOARDS - 1;
    flag_nib = (ZORRO3 != 0) ? FLAGS_Z3 : FLAGS_Z2;
    type_nib = (ZORRO3 != 0) ? TYPE_Z3 : TYPE_Z2;
`ifdef AUTOCFG_DIAGROM_EN
    if (board == 2'd0) type_nib = type_nib | 4'h1;
`endif
    mo = 2'(idx - ER_MFG);
    so = 3'(idx - ER_SERIAL);
  end

  // Nibbles are stored inverted except er_type and the reserved pair
  always_comb begin
    nib = 4'hF;
    unique case (1'b1)
      idx == ER_TYPE:
        nib = type_nib;
      idx == ER_TYPE + 7'd1:
        nib = {chain, SIZE_CODE};
      idx == ER_PROD:
        nib = ~prod[7:4];
      idx == ER_PROD + 7'd1:
        nib = ~prod[3:0];
      idx == ER_FLAGS:
        nib = ~flag_nib;
      idx == ER_FLAGS + 7'd1:
        nib = ~FLAGS_LO;
      idx[6:2] == ER_MFG[6:2]:
        nib = ~MFG_ID[{~mo, 2'b00} +: 4];
      idx >= ER_SERIAL && idx < ER_SERIAL + 7'd8:
        nib = ~SERIAL[{~so, 2'b00} +: 4];
      idx[6:1] == ER_RSVD[6:1]:
        nib = 4'h0;
`ifdef AUTOCFG_DIAGROM_EN
      idx[6:2] == ER_DIAG[6:2]:
        nib = ~DIAG_VEC[{~mo, 2'b00} +: 4];
`else
      idx[6:2] == ER_DIAG[6:2]:
        nib = ~DIAG_VEC[15:12];
`endif
      default:
        nib = 4'hF;
    endcase
  end

endmodule

// File: rtl/autoconfig_chain.sv
// Multi-board Zorro II/III AutoConfig responder (board chain on one card).
// Optional diag ROM via AUTOCFG_DIAGROM_EN (see autoconfig_rom).
module autoconfig_chain
  import autoconfig_pkg::*;
#(
  parameter int          NUM_BOARDS = 2,
  parameter int          ADDR_BITS  = 8,
  parameter int          ZORRO3     = 1,
  parameter logic [2:0]  SIZE_CODE  = 3'b100,
  parameter logic [15:0] MFG_ID     = 16'h07DB,
  parameter logic [7:0]  PROD_ID    = 8'h72,
  parameter logic [31:0] SERIAL     = 32'd421
) (
  input  logic                            CLK,
  input  logic                            RESET_n,
  input  logic                            FCS_n,
  input  logic                            DS_n,
  input  logic                            READ,
  input  logic [2:0]                      FC,
  input  logic                            CFGIN_n,
  input  logic                            match,
  input  logic [6:0]                      ADDRL,
  input  logic [ADDR_BITS-1:0]            ADDRH,
  input  logic [3:0]                      DIN,
  output logic [3:0]                      DOUT,
  output logic                            CFGOUT_n,
  output logic                            autoconfig_cycle,
  output logic [1:0]                      cur_board,
  output logic [NUM_BOARDS-1:0]           configured,
  output logic [NUM_BOARDS-1:0]           shutup,
  output logic [NUM_BOARDS*ADDR_BITS-1:0] base_addr,
  output logic [NUM_BOARDS-1:0]           hit
);

  z3_state_t state_q, state_d;

  logic [1:0]            vs;
  logic [3:0]            lo_nib;
  logic [1:0]            cur_q;
  logic [NUM_BOARDS-1:0] cfg_q;
  logic [NUM_BOARDS-1:0] shut_q;
  logic [NUM_BOARDS*ADDR_BITS-1:0] base_q;
  logic [ADDR_BITS-1:0]  new_base;
  logic [6:0]            idx;
  logic [3:0]            rom_nib;
  logic                  all_done;
  logic                  cur_done;
  logic                  data_cyc;
  logic                  end_cyc;

  assign idx      = {ADDRL[5:0], ADDRL[6]};
  assign all_done = &(cfg_q | shut_q);
  assign data_cyc = state_q == Z3_DATA;
  assign end_cyc  = state_q == Z3_END && FCS_n;

  assign autoconfig_cycle =
    match && !CFGIN_n && !all_done && vs[1];

  if (ADDR_BITS == 8) begin : g_base8
    assign new_base = {DIN, lo_nib};
  end else begin : g_base4
    assign new_base = DIN;
  end

  autoconfig_rom #(
    .NUM_BOARDS (NUM_BOARDS),
    .ZORRO3     (ZORRO3),
    .SIZE_CODE  (SIZE_CODE),
    .MFG_ID     (MFG_ID),
    .PROD_ID    (PROD_ID),
    .SERIAL     (SERIAL)
  ) u_rom (
    .idx   (idx),
    .board (cur_q),
    .nib   (rom_nib)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Z3_IDLE:
        if (!FCS_n && autoconfig_cycle) state_d = Z3_START;
      Z3_START:
        if (FCS_n)      state_d = Z3_IDLE;
        else if (!DS_n) state_d = Z3_DATA;
      Z3_DATA:
        state_d = Z3_END;
      Z3_END:
        if (FCS_n) state_d = Z3_IDLE;
      default:
        state_d = Z3_IDLE;
    endcase
  end

  always_comb begin
    cur_done = 1'b0;
    for (int k = 0; k < NUM_BOARDS; k++)
      if (cur_q == 2'(k)) cur_done = cfg_q[k] | shut_q[k];
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= Z3_IDLE;
      vs       <= 2'b00;
      DOUT     <= 4'h0;
      CFGOUT_n <= 1'b1;
      lo_nib   <= 4'hF;
      cur_q    <= 2'd0;
      cfg_q    <= '0;
      shut_q   <= '0;
      base_q   <= '1;
    end else begin
      vs      <= {vs[0], FC[1] ^ FC[0]};
      state_q <= state_d;
      if (data_cyc && READ) DOUT <= rom_nib;
      if (data_cyc && !READ && ADDRL[5:0] == ER_BASE_LO)
        lo_nib <= DIN;
      for (int k = 0; k < NUM_BOARDS; k++) begin
        if (data_cyc && !READ && cur_q == 2'(k)) begin
          if (ADDRL[5:0] == ER_BASE_HI) begin
            base_q[k*ADDR_BITS +: ADDR_BITS] <= new_base;
            cfg_q[k] <= 1'b1;
          end
          if (ADDRL[5:0] == ER_SHUTUP) shut_q[k] <= 1'b1;
        end
      end
      // Chain state only moves at cycle end so CFGOUT_n is glitch-free
      if (end_cyc) begin
        CFGOUT_n <= !all_done;
        if (cur_done && int'(cur_q) < NUM_BOARDS - 1)
          cur_q <= cur_q + 2'd1;
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_BOARDS; k++)
      hit[k] = cfg_q[k] && !shut_q[k] && vs[1] &&
               ADDRH == base_q[k*ADDR_BITS +: ADDR_BITS];
  end

  assign cur_board  = cur_q;
  assign configured = cfg_q;
  assign shutup     = shut_q;
  assign base_addr  = base_q;

endmodule

// File: tb/tb_autoconfig_chain.sv
// Randomised bench for autoconfig_chain against a byte-table ROM model
// and an abstract per-board configuration model.
module tb_autoconfig_chain;

  localparam int          NB     = 2;
  localparam int          AB     = 8;
  localparam int          Z3     = 1;
  localparam logic [2:0]  SIZE   = 3'b100;
  localparam logic [15:0] MFG    = 16'h07DB;
  localparam logic [7:0]  PROD   = 8'h72;
  localparam logic [31:0] SER    = 32'd421;

  logic          CLK = 1'b0;
  logic          RESET_n = 1'b0;
  logic          FCS_n = 1'b1;
  logic          DS_n = 1'b1;
  logic          READ = 1'b1;
  logic [2:0]    FC = 3'b001;
  logic          CFGIN_n = 1'b0;
  logic          match = 1'b0;
  logic [6:0]    ADDRL = '0;
  logic [AB-1:0] ADDRH = '0;
  logic [3:0]    DIN = '0;
  logic [3:0]    DOUT;
  logic          CFGOUT_n;
  logic          autoconfig_cycle;
  logic [1:0]    cur_board;
  logic [NB-1:0] configured;
  logic [NB-1:0] shutup;
  logic [NB*AB-1:0] base_addr;
  logic [NB-1:0] hit;

  autoconfig_chain #(
    .NUM_BOARDS (NB),
    .ADDR_BITS  (AB),
    .ZORRO3     (Z3),
    .SIZE_CODE  (SIZE),
    .MFG_ID     (MFG),
    .PROD_ID    (PROD),
    .SERIAL     (SER)
  ) dut (
    .CLK              (CLK),
    .RESET_n          (RESET_n),
    .FCS_n            (FCS_n),
    .DS_n             (DS_n),
    .READ             (READ),
    .FC               (FC),
    .CFGIN_n          (CFGIN_n),
    .match            (match),
    .ADDRL            (ADDRL),
    .ADDRH            (ADDRH),
    .DIN              (DIN),
    .DOUT             (DOUT),
    .CFGOUT_n         (CFGOUT_n),
    .autoconfig_cycle (autoconfig_cycle),
    .cur_board        (cur_board),
    .configured       (configured),
    .shutup           (shutup),
    .base_addr        (base_addr),
    .hit              (hit)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  int         m_cur;
  bit         m_cfg  [NB];
  bit         m_shut [NB];
  logic [7:0] m_base [NB];
  logic [3:0] m_lo;
  logic [3:0] m_dout;
  bit         m_cfgout;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_all_done();
    bit d = 1'b1;
    for (int k = 0; k < NB; k++) d &= m_cfg[k] | m_shut[k];
    return d;
  endfunction

  // ROM viewed as the byte-wide AutoConfig register file
  function automatic logic [3:0] rom_exp(int b, logic [6:0] idx);
    logic [7:0] by [64];
    logic [7:0] p;
    logic [3:0] ty, fl;
    logic       ch;
    for (int i = 0; i < 64; i++) by[i] = 8'hFF;
    p  = PROD + 8'(b);
    ty = Z3 ? 4'hA : 4'hE;
    fl = Z3 ? 4'hB : 4'hC;
    ch = b < NB - 1;
    by[0]  = {ty, ch, SIZE};
    by[1]  = ~p;
    by[2]  = {~fl, 4'hE};
    by[4]  = ~MFG[15:8];
    by[5]  = ~MFG[7:0];
    by[6]  = ~SER[31:24];
    by[7]  = ~SER[23:16];
    by[8]  = ~SER[15:8];
    by[9]  = ~SER[7:0];
    by[16] = 8'h00;
    return idx[0] ? by[idx[6:1]][3:0] : by[idx[6:1]][7:4];
  endfunction

  task automatic m_reset();
    m_cur = 0;
    for (int k = 0; k < NB; k++) begin
      m_cfg[k] = 0; m_shut[k] = 0; m_base[k] = 8'hFF;
    end
    m_lo = 4'hF; m_dout = 4'h0; m_cfgout = 1'b1;
  endtask

  task automatic chk_state(input string tag);
    logic [NB-1:0]    ec, es;
    logic [NB*AB-1:0] eb;
    for (int k = 0; k < NB; k++) begin
      ec[k] = m_cfg[k]; es[k] = m_shut[k];
      eb[k*AB +: AB] = m_base[k];
    end
    chk({tag, ".dout"}, 32'(DOUT), 32'(m_dout));
    chk({tag, ".cfgout"}, 32'(CFGOUT_n), 32'(m_cfgout));
    chk({tag, ".cur"}, 32'(cur_board), 32'(m_cur));
    chk({tag, ".cfg"}, 32'(configured), 32'(ec));
    chk({tag, ".shut"}, 32'(shutup), 32'(es));
    chk({tag, ".base"}, 32'(base_addr), 32'(eb));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_n = 1'b0; FCS_n = 1'b1; DS_n = 1'b1; match = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    m_reset();
    repeat (2) @(negedge CLK);
  endtask

  task automatic bus(input logic rd, input logic [6:0] al,
                     input logic [3:0] d, input int hold);
    bit act;
    @(negedge CLK);
    READ = rd; ADDRL = al; DIN = d; match = 1'b1;
    act = !CFGIN_n && !m_all_done();
    #1 chk("acyc", 32'(autoconfig_cycle), 32'(act));
    FCS_n = 1'b0;
    @(negedge CLK);
    DS_n = 1'b0;
    repeat (hold) @(negedge CLK);
    FCS_n = 1'b1; DS_n = 1'b1; match = 1'b0;
    @(negedge CLK);
    if (act) begin
      if (rd) m_dout = rom_exp(m_cur, {al[5:0], al[6]});
      else if (al[5:0] == 6'h12) m_lo = d;
      else if (al[5:0] == 6'h11) begin
        m_base[m_cur] = {d, m_lo}; m_cfg[m_cur] = 1;
      end else if (al[5:0] == 6'h13) m_shut[m_cur] = 1;
      if ((m_cfg[m_cur] || m_shut[m_cur]) && m_cur < NB - 1)
        m_cur++;
      m_cfgout = !m_all_done();
    end
    chk_state(rd ? "rd" : "wr");
  endtask

  task automatic rd_idx(input logic [6:0] idx);
    bus(1'b1, {idx[0], idx[6:1]}, 4'h0, 2 + $urandom_range(0, 3));
  endtask

  task automatic chk_hit(input logic [AB-1:0] a);
    logic [NB-1:0] eh;
    @(negedge CLK);
    ADDRH = a;
    for (int k = 0; k < NB; k++)
      eh[k] = m_cfg[k] && !m_shut[k] && m_base[k] == a;
    #1 chk("hit", 32'(hit), 32'(eh));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    repeat (3) @(negedge CLK);
    #1 chk_state("reset");
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);

    rd_idx(7'h00); chk("rd00", 32'(DOUT), 32'hA);
    rd_idx(7'h01); chk("rd01", 32'(DOUT), 32'hC);
    rd_idx(7'h02); chk("rd02", 32'(DOUT), 32'h8);
    rd_idx(7'h03); chk("rd03", 32'(DOUT), 32'hD);

    // aborted write: no register change, FSM back to idle
    @(negedge CLK);
    READ = 1'b0; ADDRL = 7'h11; DIN = 4'h3; match = 1'b1; FCS_n = 1'b0;
    @(negedge CLK);
    FCS_n = 1'b1; match = 1'b0;
    repeat (2) @(negedge CLK);
    chk_state("abort");
    rd_idx(7'h00); chk("post_abort", 32'(DOUT), 32'hA);

    bus(1'b0, 7'h12, 4'h5, 2);
    bus(1'b0, 7'h11, 4'h4, 3);
    chk("base0", 32'(base_addr[AB-1:0]), 32'h45);
    chk("cfg01", 32'(configured), 32'h1);
    chk("cur1", 32'(cur_board), 32'h1);
    rd_idx(7'h03); chk("b1rd03", 32'(DOUT), 32'hC);
    rd_idx(7'h01); chk("b1chain", 32'(DOUT), 32'h4);

    // reset pulse in DATA of a board-1 base write
    @(negedge CLK);
    READ = 1'b0; ADDRL = 7'h11; DIN = 4'h9; match = 1'b1; FCS_n = 1'b0;
    @(negedge CLK);
    DS_n = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b0;
    m_reset();
    #1 chk_state("midrst");
    FCS_n = 1'b1; DS_n = 1'b1; match = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);

    bus(1'b0, 7'h12, 4'h5, 2);
    bus(1'b0, 7'h11, 4'h4, 2);
    chk("cfgout_hold", 32'(CFGOUT_n), 32'h1);
    bus(1'b0, 7'h13, 4'h0, 2);
    chk("shut10", 32'(shutup), 32'h2);
    chk("cfgout_fall", 32'(CFGOUT_n), 32'h0);
    @(negedge CLK);
    match = 1'b1;
    #1 chk("acyc_done", 32'(autoconfig_cycle), 32'h0);
    match = 1'b0;
    chk_hit(8'h45);
    chk("hit01", 32'(hit), 32'h1);
    @(negedge CLK);
    FC = 3'b111;
    repeat (2) @(negedge CLK);
    chk("hit_fc", 32'(hit), 32'h0);
    FC = 3'b001;
    repeat (2) @(negedge CLK);

    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      for (int op = 0; op < 30; op++) begin
        int r;
        CFGIN_n = ($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 99);
        if (r < 55) begin
          rd_idx(7'($urandom_range(0, 47)));
        end else begin
          logic [6:0] al;
          int w = $urandom_range(0, 99);
          al = 7'($urandom_range(0, 127));
          if (w < 25)      al[5:0] = 6'h12;
          else if (w < 50) al[5:0] = 6'h11;
          else if (w < 62) al[5:0] = 6'h13;
          bus(1'b0, al, 4'($urandom), 2 + $urandom_range(0, 3));
        end
        if ($urandom_range(0, 1) == 1)
          chk_hit(m_base[$urandom_range(0, NB - 1)]);
        else
          chk_hit(8'($urandom));
      end
    end
    CFGIN_n = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/autoconfig_chain.md
# autoconfig_chain

Parametrised Zorro II/III AutoConfig responder that presents 1–4 logical boards in sequence on one physical card. It sits between the bus-cycle front end and the memory/ROM decoders. It serves each board's AutoConfig ROM nibbles, latches the base address the OS assigns to each board, and drives CFGOUT_n only after every board is configured or shut up. Per-board hit flags feed the downstream RAM decoders.

## Interface
Parameters:
- NUM_BOARDS, 2 — logical boards in the chain, 1..4.
- ADDR_BITS, 8 — base-address bits latched per board, 4 or 8.
- ZORRO3, 1 — 1: Zorro III type/flags nibbles; 0: Zorro II.
- SIZE_CODE, 3'b100 — er_type size field, shared by all boards.
- MFG_ID, 16'h07DB — manufacturer ID.
- PROD_ID, 8'h72 — product ID of board 0; board k reports PROD_ID+k.
- SERIAL, 32'd421 — serial number reported by all boards.

Ports:
- CLK  in  1  system clock.
- RESET_n  in  1  reset, asynchronous, active-low.
- FCS_n  in  1  full cycle strobe, active-low.
- DS_n  in  1  any data strobe, active-low.
- READ  in  1  1 = read cycle.
- FC  in  3  function code.
- CFGIN_n  in  1  chain enable from the previous card, active-low.
- match  in  1  address is in AutoConfig space.
- ADDRL  in  7  low address bits A[8:2].
- ADDRH  in  ADDR_BITS  high address bits compared against base addresses.
- DIN  in  4  write data nibble.
- DOUT  out  4  registered read nibble.
- CFGOUT_n  out  1  chain enable to the next card, active-low.
- autoconfig_cycle  out  1  current cycle targets this responder.
- cur_board  out  2  index of the board being configured.
- configured  out  NUM_BOARDS  per-board configured flag.
- shutup  out  NUM_BOARDS  per-board shut-up flag.
- base_addr  out  NUM_BOARDS*ADDR_BITS  packed base addresses; board k is at [k*ADDR_BITS +: ADDR_BITS].
- hit  out  NUM_BOARDS  hit[k] = configured[k] && !shutup[k] && ADDRH==base k && vs[1].

## Operation
- validspace = FC[1]^FC[0]. It passes through a 2-flop synchroniser, giving vs[1:0].
- autoconfig_cycle = match && !CFGIN_n && !all_done && vs[1]. all_done is set when every board k < NUM_BOARDS has configured or shutup.
- Cycle FSM:
  - IDLE→START when !FCS_n && autoconfig_cycle.
  - START→IDLE if FCS_n; START→DATA if !DS_n; otherwise stay in START.
  - DATA→END unconditionally.
  - END→IDLE when FCS_n.
- Register index idx = {ADDRL[5:0],ADDRL[6]}.
- Reads in DATA. DOUT is loaded per idx for board cur_board:
  - 00: ZORRO3 ? 4'hA : 4'hE.
  - 01: {chain, SIZE_CODE}. chain = 1 when cur_board < NUM_BOARDS-1.
  - 02/03: ~(PROD_ID+cur_board), high then low nibble.
  - 04: ZORRO3 ? ~4'hB : ~4'hC.
  - 05: ~4'h1.
  - 08–0B: ~MFG_ID nibbles, MSB first.
  - 0C–13: ~SERIAL nibbles, MSB first.
  - 20/21: 4'h0.
  - All others: 4'hF.
- Writes in DATA, decoded on ADDRL[5:0]:
  - 6'h12: lo_nib ← DIN. Used only when ADDR_BITS=8.
  - 6'h11: base[cur_board] ← {DIN, lo_nib} (or DIN when ADDR_BITS=4), and configured[cur_board] ← 1.
  - 6'h13: shutup[cur_board] ← 1.
  - Other write offsets are ignored.
- Board advance: on the END→IDLE transition, if the current board is configured or shut up, cur_board increments. It saturates at NUM_BOARDS-1.
- CFGOUT_n ← !all_done. It is updated only on the END→IDLE transition, so it never changes mid-cycle.

## Timing
- Reset values: DOUT=0, CFGOUT_n=1, configured=0, shutup=0, all bases all-ones, lo_nib=4'hF, cur_board=0, FSM=IDLE.
- Minimum cycle: IDLE, START, DATA, END. DOUT is valid from the clock after DATA and is held until the next read.
- Each bus cycle produces exactly one DATA state, even if DS_n stays low for many clocks.
- The new board's ROM is visible on the cycle after the advance.
- If FCS_n deasserts in START, the FSM aborts with no register update.
- RESET_n mid-cycle forces the FSM to IDLE and restores all reset values immediately.
- A write to 0x11 after a shut-up of the same board cannot occur, because the board advances first.
- With CFGIN_n high, no cycle starts. Any already-started cycle completes.

## Configuration
- AUTOCFG_DIAGROM_EN defined:
  - Board 0 sets the er_type ROM bit (nibble 00 = ZORRO3 ? 4'hB : 4'hF).
  - Offsets 0x14/0x15 return ~8'h00 and 0x16/0x17 return ~8'h10, giving a diag vector of 0x0010.
- Not defined: these offsets return 4'hF and the ROM bit is clear.

## Structure
- Package autoconfig_pkg holds:
  - FSM state encoding (Z3_IDLE..Z3_END).
  - Register-offset constants (ER_TYPE, ER_PROD, ER_FLAGS, ER_MFG, ER_SERIAL, ER_BASE_HI=6'h11, ER_BASE_LO=6'h12, ER_SHUTUP=6'h13).
  - The type/flag nibble constants.
- Sub-module autoconfig_rom: combinational nibble lookup from (idx, board index) to the read value. The top level keeps the FSM, board pointer and registers.

## Test plan
- NUM_BOARDS=2, ADDR_BITS=8: read board 0 at idx 00–03 → A, {1,100}, ~7, ~2. Read board 1 at idx 03 → ~3, chain bit 0.
- Write 0x12=4'h5 then 0x11=4'h4 → base 0 = 8'h45, configured=2'b01, cur_board=1, CFGOUT_n still 1.
- Board 1: write 0x13 → shutup=2'b10. CFGOUT_n falls at that cycle's FCS_n rise. The next match cycle gives autoconfig_cycle=0.
- After configuring, ADDRH=8'h45 with FC=3'b001 → hit=2'b01. FC=3'b111 → hit=0 after two clocks.
- Assert FCS_n in START with DS_n never low → no DOUT change, FSM back to IDLE.
- Pulse RESET_n during DATA of a 0x11 write → configured=0, base = all-ones, CFGOUT_n=1.
